credit_link: RTL
================

# credit_link

Parametrised point-to-point link between two routers in the 3-D torus. It replaces the fixed-latency internode link, which has no flow control, with a credit-flow-controlled link. The block combines four parts:
- a transmit-side credit counter;
- a DELAY-stage serial pipeline carrying {valid, flit};
- a receive FIFO of depth CREDITS;
- a DELAY-stage credit-return pipeline.

One instance sits on each of the six router ports in a node. Flits are never dropped, and in-order delivery is guaranteed.

## Interface
Parameters:
- FLIT_W, 256: flit payload width.
- DELAY, 4: one-way link latency in register stages, ≥1, applied to both flits and credits.
- CREDITS, 16: receive FIFO depth and initial credit count, power of two, ≥2.
- CW, $clog2(CREDITS+1): width of the credit and occupancy counters.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous, active-low.
- tx_data  in  FLIT_W  flit from the router output port.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  at least one credit is available.
- ser_out  out  FLIT_W+1  serial-side view of the pipeline head: {valid, flit}, valid is the MSB.
- rx_data  out  FLIT_W  FIFO head, first-word fall-through.
- rx_valid  out  1  FIFO is non-empty.
- rx_ready  in  1  consumer pops the head.
- tx_credits  out  CW  current credit count.
- rx_count  out  CW  current FIFO occupancy.
- overflow_err  out  1  sticky: a push occurred while the FIFO was full.

## Operation
- Accept: tx_valid & tx_ready in a cycle.
- Accept behaviour: {1, tx_data} enters forward pipeline stage 0, and tx_credits decrements by 1.
- No accept: stage 0 loads {0, don't-care}.
- Forward pipeline: DELAY registers. ser_out is the last stage.
- Push: when the last stage's valid bit is 1, the flit is written to the FIFO tail.
- Pop: rx_valid & rx_ready in a cycle. The head advances, and a 1 enters credit-return pipeline stage 0.
- Credit return: the credit pipeline is DELAY 1-bit registers. When its last stage is 1, tx_credits increments by 1.
- Decrement and increment in the same cycle: tx_credits is unchanged.
- Push and pop in the same cycle, FIFO full: both occur, and rx_count is unchanged.
- Push and pop in the same cycle, FIFO empty: the pop is illegal because rx_valid=0. The push occurs.
- Push while full: the flit is discarded, overflow_err sets, and it holds until reset. This is unreachable with correct credit accounting and is flagged as an error only.
- FIFO pointers are log2(CREDITS) bits and wrap modulo CREDITS. Full/empty are decided by rx_count, not by the pointers.
- tx_credits never exceeds CREDITS. Any increment that would exceed CREDITS is a bench-checked error; the RTL saturates.
- tx_valid without tx_ready: no effect. The sender holds the flit.

## Timing
Reset (rst low, asynchronous):
- All pipeline valid bits and credit bits clear.
- FIFO pointers and rx_count are 0.
- tx_credits = CREDITS and overflow_err = 0.
- Resulting outputs: tx_ready=1 (since CREDITS≥2), rx_valid=0, ser_out=0, rx_data=0.
- Reset mid-operation discards all in-flight flits and credits. Behaviour after reset is identical to power-up.

Latency and throughput:
- Flit latency: accepted in cycle 0, it appears at ser_out in cycle DELAY and with rx_valid=1 in cycle DELAY+1.
- Credit latency: a pop in cycle p makes tx_credits +1 visible in cycle p+DELAY+1.
- Round trip (accept to credit back) is 2·DELAY+2 cycles.
- One flit per cycle is sustained only if CREDITS ≥ 2·DELAY+2. Otherwise throughput is CREDITS/(2·DELAY+2).
- tx_ready is combinational from tx_credits≠0. It is never combinational from tx_valid.
- rx_valid/rx_data are registered state and are not combinational from rx_ready.

## Test plan
Benches use FLIT_W=8 unless noted.
- Reset (DELAY=3, CREDITS=4): hold rst low for 3 cycles, releasing mid-traffic → tx_credits=4, tx_ready=1, rx_valid=0, rx_count=0, ser_out=0, overflow_err=0.
- Single flit (DELAY=3, CREDITS=4): accept 0xA5 in cycle 0, rx_ready=1 → rx_valid=1 with rx_data=0xA5 only in cycle 4; tx_credits is 3 in cycles 1–7 and 4 in cycle 8.
- Back-pressure (DELAY=3, CREDITS=4): rx_ready=0, tx_valid=1 for 6 cycles with data 1..6 → exactly 4 accepted; tx_ready=0 from cycle 4; rx_count=4; overflow_err=0; popping then yields 1,2,3,4 in order.
- Full rate (DELAY=3, CREDITS=8): 100 back-to-back flits 0..99, rx_ready=1 → tx_ready never deasserts; outputs are 0..99 in order at one per cycle.
- Simultaneous events (DELAY=2, CREDITS=4): arrange an accept in the same cycle a credit returns → tx_credits is unchanged that cycle; a FIFO push and pop in the same cycle at rx_count=4 → rx_count stays 4.
- Random stress (DELAY=5, CREDITS=16): 10k cycles of random tx_valid/rx_ready at 50%, plus one reset mid-run → scoreboard matches; tx_credits + in-flight flits + rx_count + in-flight credits = 16 every cycle; overflow_err=0.

Source files
------------

// File: rtl/credit_link_if.sv
// Handshake and status bundle between a router port and its credit link.
// master = router/consumer side, slave = the link itself.
interface credit_link_if #(
    parameter int FLIT_W  = 256,
    parameter int CREDITS = 16,
    parameter int CW      = $clog2(CREDITS + 1)
);
    logic [FLIT_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [FLIT_W:0]   ser_out;
    logic [FLIT_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [CW-1:0]     tx_credits;
    logic [CW-1:0]     rx_count;
    logic              overflow_err;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, ser_out, rx_data, rx_valid,
        input  tx_credits, rx_count, overflow_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, ser_out, rx_data, rx_valid,
        output tx_credits, rx_count, overflow_err
    );
endinterface

// File: rtl/credit_link.sv
// Credit-flow-controlled torus link: credit counter, flit delay line,
// receive FIFO and credit-return delay line in one block.
module credit_link #(
    parameter int FLIT_W  = 256,
    parameter int DELAY   = 4,
    parameter int CREDITS = 16,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input logic          clk,
    input logic          rst,
    credit_link_if.slave link
);
    localparam int PW = $clog2(CREDITS);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [FLIT_W:0]   fwd_q [DELAY];
    logic [FLIT_W:0]   fwd_d [DELAY];
    logic [DELAY-1:0]  ret_q, ret_d;
    logic [FLIT_W-1:0] mem_q [CREDITS];
    logic [FLIT_W-1:0] mem_d [CREDITS];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic              ovf_q, ovf_d;

    logic accept, push, pop, ret, full, empty, write;

    always_comb begin
        accept = link.tx_valid & (credits_q != '0);
        full   = (count_q == CRED_MAX);
        empty  = (count_q == '0);
        pop    = link.rx_ready & ~empty;
        push   = fwd_q[DELAY-1][FLIT_W];
        ret    = ret_q[DELAY-1];
        // A full FIFO still takes a push when the head leaves this cycle.
        write  = push & (~full | pop);

        fwd_d[0] = accept ? {1'b1, link.tx_data} : '0;
        for (int i = 1; i < DELAY; i++) begin
            fwd_d[i] = fwd_q[i-1];
        end

        ret_d[0] = pop;
        for (int i = 1; i < DELAY; i++) begin
            ret_d[i] = ret_q[i-1];
        end

        credits_d = credits_q;
        unique case (1'b1)
            accept && !ret: credits_d = credits_q - CW'(1);
            ret && !accept && credits_q != CRED_MAX:
                credits_d = credits_q + CW'(1);
            default: ;
        endcase

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (write) begin
            mem_d[wr_ptr_q] = fwd_q[DELAY-1][FLIT_W-1:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(write) - CW'(pop);
        ovf_d   = ovf_q | (push & full & ~pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DELAY; i++) begin
                fwd_q[i] <= '0;
            end
            for (int i = 0; i < CREDITS; i++) begin
                mem_q[i] <= '0;
            end
            ret_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= CRED_MAX;
            ovf_q     <= 1'b0;
        end else begin
            fwd_q     <= fwd_d;
            mem_q     <= mem_d;
            ret_q     <= ret_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            ovf_q     <= ovf_d;
        end
    end

    assign link.tx_ready     = (credits_q != '0);
    assign link.ser_out      = fwd_q[DELAY-1];
    assign link.rx_data      = mem_q[rd_ptr_q];
    assign link.rx_valid     = ~empty;
    assign link.tx_credits   = credits_q;
    assign link.rx_count     = count_q;
    assign link.overflow_err = ovf_q;
endmodule
